// File: rtl/gp_engine_pkg.sv
// gp_engine_pkg: shared definitions for the command executor.
// Holds command type encodings, command field bit positions and the FSM state type.
package gp_engine_pkg;

    // Command type encodings (cmd[1:0]); 2'b10 and 2'b11 are illegal
    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_RWM   = 2'b01;

    // Command word field positions
    localparam int CMD_TYPE_LSB = 0;
    localparam int CMD_TYPE_MSB = 1;
    localparam int CMD_DATA_LSB = 2;
    localparam int CMD_DATA_MSB = 33;
    localparam int CMD_ADDR_LSB = 34;
    localparam int CMD_ADDR_MSB = 63;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_FETCH2,
        ST_MOD_WR,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/gp_cmd_decode.sv
// gp_cmd_decode: combinational split of a command word into its fields.
// Ports: cmd_i (command word) -> addr_o (word-aligned), data_o, zero_o, write_o, rwm_o.
module gp_cmd_decode
    import gp_engine_pkg::*;
#(
    parameter int CMD_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [CMD_WIDTH-1:0]  cmd_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  zero_o,
    output logic                  write_o,
    output logic                  rwm_o
);

    logic [1:0] type_w;

    assign type_w  = cmd_i[CMD_TYPE_MSB:CMD_TYPE_LSB];
    assign addr_o  = {cmd_i[CMD_ADDR_MSB:CMD_ADDR_LSB], 2'b00};
    assign data_o  = cmd_i[CMD_DATA_MSB:CMD_DATA_LSB];
    assign zero_o  = (cmd_i == '0);
    assign write_o = (type_w == CMD_WRITE);
    assign rwm_o   = (type_w == CMD_RWM);

endmodule

// File: rtl/cmd_exec_fsm.sv
// cmd_exec_fsm: fetches command words from a buffer and executes them on a
// bus master as plain writes or read-modify-write pairs (RWM + WRITE).
// Ports: start/busy/done/err control; cmd_rd_en/cmd_addr/cmd_rd_valid/cmd_out
// command buffer; mst_o_* / mst_i_* bus request, handshake and read return.
module cmd_exec_fsm
    import gp_engine_pkg::*;
#(
    parameter int                    CMD_WIDTH  = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 32'h0000_04A0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cmd_rd_en,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_rd_valid,
    input  logic [CMD_WIDTH-1:0]  cmd_out,
    output logic                  mst_o_valid,
    output logic [ADDR_WIDTH-1:0] mst_o_addr,
    output logic [DATA_WIDTH-1:0] mst_o_wr_data,
    output logic                  mst_o_rd0_wr1,
    input  logic                  mst_i_ready,
    input  logic [DATA_WIDTH-1:0] mst_i_rd_data,
    input  logic                  mst_i_rd_valid
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  busy_q, done_q, rd_en_q, valid_q;
    logic [ADDR_WIDTH-1:0] next_idx;

    logic [CMD_WIDTH-1:0]  dec_cmd;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic [DATA_WIDTH-1:0] dec_data;
    logic                  dec_zero, dec_write, dec_rwm;

    // The companion WRITE of an RWM is checked as it arrives, so FETCH2
    // decodes the buffer word directly; elsewhere the captured word is used.
    assign dec_cmd  = (state_q == ST_FETCH2) ? cmd_out : cmd_q;
    assign next_idx = cmd_addr_q + STEP;

    gp_cmd_decode #(
        .CMD_WIDTH (CMD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dec (
        .cmd_i  (dec_cmd),
        .addr_o (dec_addr),
        .data_o (dec_data),
        .zero_o (dec_zero),
        .write_o(dec_write),
        .rwm_o  (dec_rwm)
    );

    always_comb begin
        state_d    = state_q;
        cmd_addr_d = cmd_addr_q;
        cmd_d      = cmd_q;
        rdata_d    = rdata_q;
        mask_d     = mask_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    cmd_addr_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (cmd_rd_valid) begin
                    cmd_d   = cmd_out;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_zero || (cmd_addr_q == END_ADDR)) begin
                    state_d = ST_DONE;
                end else if (dec_write) begin
                    maddr_d = dec_addr;
                    wdata_d = dec_data;
                    we_d    = 1'b1;
                    state_d = ST_WR_REQ;
                end else if (dec_rwm) begin
                    maddr_d = dec_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    mask_d  = dec_data;
                    state_d = ST_RD_REQ;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_WR_REQ, ST_MOD_WR: begin
                if (mst_i_ready) begin
                    cmd_addr_d = next_idx;
                    state_d    = ST_FETCH;
                end
            end
            ST_RD_REQ: begin
                if (mst_i_ready) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mst_i_rd_valid) begin
                    rdata_d    = mst_i_rd_data;
                    cmd_addr_d = next_idx;
                    // An RWM in the last slot has no WRITE partner to fetch
                    state_d    = (next_idx == END_ADDR) ? ST_ERR : ST_FETCH2;
                end
            end
            ST_FETCH2: begin
                if (cmd_rd_valid) begin
                    cmd_d = cmd_out;
                    if (!dec_zero && dec_write) begin
                        maddr_d = dec_addr;
                        wdata_d = (rdata_q & ~mask_q) | (dec_data & mask_q);
                        we_d    = 1'b1;
                        state_d = ST_MOD_WR;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_addr_q <= '0;
            cmd_q      <= '0;
            rdata_q    <= '0;
            mask_q     <= '0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_q      <= cmd_d;
            rdata_q    <= rdata_d;
            mask_q     <= mask_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            rd_en_q    <= (state_d == ST_FETCH) || (state_d == ST_FETCH2);
            valid_q    <= (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ) ||
                          (state_d == ST_MOD_WR);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign cmd_rd_en     = rd_en_q;
    assign cmd_addr      = cmd_addr_q;
    assign mst_o_valid   = valid_q;
    assign mst_o_addr    = maddr_q;
    assign mst_o_wr_data = wdata_q;
    assign mst_o_rd0_wr1 = we_q;

endmodule

// File: tb/tb_cmd_exec_fsm.sv
// tb_cmd_exec_fsm: randomized bench for cmd_exec_fsm with a command-list
// reference model, buffer/bus responders and a per-cycle compare process.
module tb_cmd_exec_fsm;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          CW    = 64;
    localparam logic [31:0] END_A = 32'h0000_04A0;
    localparam int          NENT  = 297;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err, cmd_rd_en;
    logic [AW-1:0] cmd_addr;
    logic          cmd_rd_valid = 1'b0;
    logic [CW-1:0] cmd_out = '0;
    logic          mst_o_valid, mst_o_rd0_wr1;
    logic [AW-1:0] mst_o_addr;
    logic [DW-1:0] mst_o_wr_data;
    logic          mst_i_ready = 1'b0;
    logic [DW-1:0] mst_i_rd_data = '0;
    logic          mst_i_rd_valid = 1'b0;

    always #5 clk = ~clk;

    cmd_exec_fsm #(
        .CMD_WIDTH (CW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .END_ADDR  (END_A)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cmd_rd_en     (cmd_rd_en),
        .cmd_addr      (cmd_addr),
        .cmd_rd_valid  (cmd_rd_valid),
        .cmd_out       (cmd_out),
        .mst_o_valid   (mst_o_valid),
        .mst_o_addr    (mst_o_addr),
        .mst_o_wr_data (mst_o_wr_data),
        .mst_o_rd0_wr1 (mst_o_rd0_wr1),
        .mst_i_ready   (mst_i_ready),
        .mst_i_rd_data (mst_i_rd_data),
        .mst_i_rd_valid(mst_i_rd_valid)
    );

    logic [63:0] mem [NENT];
    logic [31:0] rdv [64];
    logic [31:0] bus_rdq [$];
    tx_t         exp_tx [$];
    logic [31:0] exp_fetch [$];
    bit          exp_done, exp_err;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  n_wr_seen, n_done_seen, n_stall;
    tx_t last_wr, prev_req, mon_e;
    int  hold_ready = 0;
    bit  hold_rd = 1'b0;
    bit  fpend, rpend, pv, pr;
    int  fcnt, rcnt;

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(logic [31:0] a, logic [31:0] d, logic [1:0] t);
        return {a[31:2], d, t};
    endfunction

    function automatic logic [31:0] fa(logic [63:0] c);
        return {c[63:34], 2'b00};
    endfunction

    function automatic logic [31:0] fd(logic [63:0] c);
        return c[33:2];
    endfunction

    // Walk the command list the way the executor must, listing every
    // fetch index, every bus request and the final outcome.
    task automatic build_model();
        int          idx = 0;
        int          ri  = 0;
        bit          fin = 0;
        logic [63:0] c, c2;
        logic [31:0] rd, m;
        exp_tx.delete();
        exp_fetch.delete();
        exp_done = 0;
        exp_err  = 0;
        while (!fin) begin
            exp_fetch.push_back(32'(idx * 4));
            c = mem[idx];
            if (c == 64'h0 || 32'(idx * 4) == END_A) begin
                exp_done = 1; fin = 1;
            end else if (c[1:0] == 2'b00) begin
                exp_tx.push_back({1'b1, fa(c), fd(c)});
                idx++;
            end else if (c[1:0] == 2'b01) begin
                exp_tx.push_back({1'b0, fa(c), 32'h0});
                rd = rdv[ri]; ri++;
                m  = fd(c);
                idx++;
                if (32'(idx * 4) == END_A) begin
                    exp_err = 1; fin = 1;
                end else begin
                    exp_fetch.push_back(32'(idx * 4));
                    c2 = mem[idx];
                    if (c2 == 64'h0 || c2[1:0] != 2'b00) begin
                        exp_err = 1; fin = 1;
                    end else begin
                        exp_tx.push_back({1'b1, fa(c2), (rd & ~m) | (fd(c2) & m)});
                        idx++;
                    end
                end
            end else begin
                exp_err = 1; fin = 1;
            end
        end
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 64'h0;
        foreach (rdv[i]) rdv[i] = $urandom;
    endtask

    // Buffer and bus responders plus per-cycle checks, all at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            cmd_rd_valid   = 1'b0;
            mst_i_ready    = 1'b0;
            mst_i_rd_valid = 1'b0;
            fpend = 0; rpend = 0; pv = 0; pr = 0;
        end else begin
            if (mst_o_valid) chk("valid_needs_busy", busy, 1'b1);
            if (done) begin
                chk("done_needs_busy", busy, 1'b1);
                n_done_seen++;
            end
            if (pv && !pr) begin
                chk("req_held_valid", mst_o_valid, 1'b1);
                chk("req_held_fields", {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data}, prev_req);
            end

            if (!cmd_rd_en) begin
                fpend = 0;
                cmd_rd_valid = ($urandom_range(0, 7) == 0);
                cmd_out = {$urandom, $urandom};
            end else if (!fpend) begin
                fpend = 1;
                fcnt  = $urandom_range(0, 2);
                cmd_rd_valid = 1'b0;
            end else if (fcnt == 0) begin
                cmd_rd_valid = 1'b1;
                cmd_out = (cmd_addr[31:2] < NENT) ? mem[cmd_addr[31:2]] : 64'h0;
                if (exp_fetch.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL fetch_extra: got fetch at %0h, required none", cmd_addr);
                end else begin
                    chk("fetch_addr", cmd_addr, exp_fetch.pop_front());
                end
            end else begin
                fcnt--;
                cmd_rd_valid = 1'b0;
            end

            if (rpend) begin
                if (rcnt == 0 && !hold_rd) begin
                    mst_i_rd_valid = 1'b1;
                    mst_i_rd_data  = (bus_rdq.size() > 0) ? bus_rdq.pop_front() : 32'h0;
                    rpend = 0;
                end else begin
                    if (rcnt > 0) rcnt--;
                    mst_i_rd_valid = 1'b0;
                end
            end else begin
                mst_i_rd_valid = ($urandom_range(0, 7) == 0);
                mst_i_rd_data  = $urandom;
            end

            if (mst_o_valid && hold_ready > 0) begin
                mst_i_ready = 1'b0;
                hold_ready--;
                n_stall++;
            end else begin
                mst_i_ready = ($urandom_range(0, 3) != 0);
            end

            if (mst_o_valid && mst_i_ready) begin
                if (exp_tx.size() == 0) begin
                    n_assert++; n_fail++;
                    $display("FAIL bus_extra: got req %0h, required none", mst_o_addr);
                end else begin
                    mon_e = exp_tx.pop_front();
                    chk("bus_rd0_wr1", mst_o_rd0_wr1, mon_e.we);
                    chk("bus_addr", mst_o_addr, mon_e.addr);
                    if (mon_e.we) chk("bus_wr_data", mst_o_wr_data, mon_e.data);
                end
                if (mst_o_rd0_wr1) begin
                    n_wr_seen++;
                    last_wr = {1'b1, mst_o_addr, mst_o_wr_data};
                end else begin
                    rpend = 1;
                    rcnt  = $urandom_range(0, 3);
                end
            end
            pv = mst_o_valid;
            pr = mst_i_ready;
            prev_req = {mst_o_rd0_wr1, mst_o_addr, mst_o_wr_data};
        end
    end

    task automatic run_prog(int max_cyc);
        int cyc = 0;
        build_model();
        bus_rdq.delete();
        foreach (rdv[i]) bus_rdq.push_back(rdv[i]);
        n_wr_seen = 0;
        n_done_seen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("err_cleared_by_start", err, 1'b0);
        while (busy && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            start = busy && ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        #1;
        chk("run_finished", busy, 1'b0);
        chk("done_pulses", n_done_seen, exp_done);
        chk("err_flag", err, exp_err);
        chk("bus_reqs_left", exp_tx.size(), 0);
        chk("fetches_left", exp_fetch.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_rd_en"}, cmd_rd_en, 1'b0);
        chk({tag, "_cmd_addr"}, cmd_addr, 32'h0);
        chk({tag, "_valid"}, mst_o_valid, 1'b0);
        chk({tag, "_addr"}, mst_o_addr, 32'h0);
        chk({tag, "_wdata"}, mst_o_wr_data, 32'h0);
        chk({tag, "_wr1"}, mst_o_rd0_wr1, 1'b0);
    endtask

    task automatic gen_random();
        int i = 0;
        int n = $urandom_range(1, 12);
        int r;
        clear_mem();
        foreach (mem[k]) mem[k] = mk($urandom, $urandom, 2'($urandom_range(0, 3)));
        repeat (n) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                mem[i] = mk($urandom, $urandom, 2'b00); i++;
            end else if (r <= 7) begin
                mem[i] = mk($urandom, $urandom, 2'b01); i++;
                mem[i] = mk($urandom, $urandom, 2'b00); i++;
            end else if (r == 8) begin
                mem[i] = mk($urandom, $urandom, 2'b01); i++;
                mem[i] = mk($urandom, $urandom, 2'($urandom_range(1, 3))); i++;
            end else begin
                mem[i] = mk($urandom, $urandom, 2'($urandom_range(2, 3))); i++;
            end
        end
        mem[i] = 64'h0;
    endtask

    initial begin
        int cyc;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single write then terminator
        clear_mem();
        mem[0] = mk(32'h100, 32'hDEADBEEF, 2'b00);
        build_model();
        chk("pin_single_ntx", exp_tx.size(), 1);
        chk("pin_single_tx", exp_tx[0], {1'b1, 32'h100, 32'hDEADBEEF});
        run_prog(1000);
        chk("single_nwr", n_wr_seen, 1);
        chk("single_wr", last_wr, {1'b1, 32'h100, 32'hDEADBEEF});
        chk("single_err", err, 1'b0);

        // Read-modify-write
        clear_mem();
        mem[0] = mk(32'h200, 32'h0000FF00, 2'b01);
        mem[1] = mk(32'h200, 32'h00001200, 2'b00);
        rdv[0] = 32'hAABBCCDD;
        build_model();
        chk("pin_rwm_data", exp_tx[1].data, 32'hAABB12DD);
        run_prog(1000);
        chk("rwm_wr", last_wr, {1'b1, 32'h200, 32'hAABB12DD});

        // RWM followed by RWM
        clear_mem();
        mem[0] = mk(32'h200, 32'h0000FF00, 2'b01);
        mem[1] = mk(32'h204, 32'h000000FF, 2'b01);
        build_model();
        chk("pin_rwm_rwm_err", exp_err, 1'b1);
        run_prog(1000);
        chk("rwm_rwm_nwr", n_wr_seen, 0);
        chk("rwm_rwm_err", err, 1'b1);

        // Ready held low for 5 cycles on a write
        clear_mem();
        mem[0] = mk(32'h340, 32'h12345678, 2'b00);
        n_stall = 0;
        hold_ready = 5;
        run_prog(1000);
        chk("stall_cycles", n_stall, 5);
        chk("stall_nwr", n_wr_seen, 1);

        // Illegal type
        clear_mem();
        mem[0] = mk(32'h10, 32'h1, 2'b00);
        mem[1] = mk(32'h20, 32'h2, 2'b10);
        run_prog(1000);
        chk("illegal_err", err, 1'b1);
        chk("illegal_nwr", n_wr_seen, 1);

        // RWM in the last slot
        clear_mem();
        for (int i = 0; i < 295; i++) mem[i] = mk(32'(i * 8), $urandom, 2'b00);
        mem[295] = mk(32'h400, 32'hFFFF, 2'b01);
        mem[296] = mk(32'h404, 32'h1, 2'b00);
        run_prog(6000);
        chk("last_rwm_err", err, 1'b1);
        chk("last_rwm_nwr", n_wr_seen, 295);

        // Full buffer of writes
        clear_mem();
        for (int i = 0; i < 296; i++) mem[i] = mk(32'(i * 4), $urandom, 2'b00);
        mem[296] = mk(32'hFFC, 32'hBAD, 2'b00);
        build_model();
        chk("pin_full_ntx", exp_tx.size(), 296);
        run_prog(6000);
        chk("full_nwr", n_wr_seen, 296);
        chk("full_done", n_done_seen, 1);

        // Reset while waiting for read data
        clear_mem();
        mem[0] = mk(32'h300, 32'h0000000F, 2'b01);
        mem[1] = mk(32'h300, 32'h00000005, 2'b00);
        build_model();
        bus_rdq.delete();
        foreach (rdv[i]) bus_rdq.push_back(rdv[i]);
        hold_rd = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!rpend && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_rd_wait", rpend, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        hold_rd = 1'b0;
        exp_tx.delete();
        exp_fetch.delete();
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_valid", mst_o_valid, 1'b0);
        rdv[0] = 32'h000000A0;
        run_prog(1000);
        chk("post_rst_wr", last_wr, {1'b1, 32'h300, 32'h000000A5});

        // Random command lists
        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_prog(2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required end before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmd_exec_fsm.md
CMD_EXEC_FSM -- requirements
Module: cmd_exec_fsm

Interface
REQ-001 Parameters, SHALL be provided as: CMD_WIDTH, 64, command word width; ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; END_ADDR, 32'h0000_04A0, command index at which the executor stops.
REQ-002 Ports, SHALL be provided as follows (name, direction, width, meaning):
- clk  in  1  single clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at index 0.
- busy  out  1  executor is active.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky; cleared by the next start.
- cmd_rd_en  out  1  command fetch request to the buffer.
- cmd_addr  out  ADDR_WIDTH  command index; steps by 4.
- cmd_rd_valid  in  1  buffer read data is valid.
- cmd_out  in  CMD_WIDTH  fetched command word.
- mst_o_valid  out  1  bus request.
- mst_o_addr  out  ADDR_WIDTH  bus address (word-aligned).
- mst_o_wr_data  out  DATA_WIDTH  bus write data.
- mst_o_rd0_wr1  out  1  1 = write, 0 = read.
- mst_i_ready  in  1  bus accepts the request.
- mst_i_rd_data  in  DATA_WIDTH  bus read data.
- mst_i_rd_valid  in  1  bus read data is valid.

Function
REQ-003 Command word decode SHALL be: addr = {cmd[63:34], 2'b00}; data = cmd[33:2]; type = cmd[1:0]; WRITE = 2'b00, RWM = 2'b01; 2'b10 and 2'b11 are illegal.
REQ-004 The state machine SHALL have states IDLE, FETCH, DECODE, WR_REQ, RD_REQ, RD_WAIT, FETCH2, MOD_WR, DONE and ERR.
REQ-005 In IDLE, start SHALL clear err, set cmd_addr to 0, and move to FETCH; start SHALL be ignored in every other state.
REQ-006 In FETCH and FETCH2, cmd_rd_en SHALL be held high until cmd_rd_valid; cmd_out SHALL be captured on that cycle.
REQ-007 In DECODE, an all-zero command word or cmd_addr == END_ADDR SHALL go to DONE, WRITE SHALL go to WR_REQ, RWM SHALL go to RD_REQ, and an illegal type SHALL go to ERR.
REQ-008 In WR_REQ: mst_o_valid=1, mst_o_rd0_wr1=1, mst_o_addr=addr, mst_o_wr_data=data, held stable until mst_i_ready; then cmd_addr += 4 and move to FETCH.
REQ-009 In RD_REQ: mst_o_valid=1, mst_o_rd0_wr1=0, mst_o_addr=RWM addr; on mst_i_ready move to RD_WAIT.
REQ-010 In RD_WAIT: on mst_i_rd_valid, capture rdata, cmd_addr += 4, move to FETCH2.
REQ-011 The command following an RWM SHALL be of type WRITE; otherwise, or if the RWM is the last entry (cmd_addr == END_ADDR), the FSM SHALL move to ERR with no bus write.
REQ-012 In MOD_WR: write (rdata & ~rwm_data) | (wr_data & rwm_data) to the WRITE entry's address, using the WR_REQ handshake; then cmd_addr += 4 and move to FETCH.
REQ-013 DONE SHALL pulse done for 1 cycle, then move to IDLE; ERR SHALL set err, then move to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 mst_o_valid SHALL be 0 outside WR_REQ, RD_REQ and MOD_WR; mst_o_valid SHALL never drop before mst_i_ready.
REQ-016 Index arithmetic SHALL be ADDR_WIDTH-bit; the END_ADDR check SHALL occur before any fetch beyond it, so no wrap-around is possible.
REQ-017 Latency: a fetch SHALL take at least 2 cycles; a WRITE SHALL cost a minimum of 4 cycles from FETCH entry with ready tied high.
REQ-018 mst_i_rd_valid SHALL be ignored outside RD_WAIT, and cmd_rd_valid SHALL be ignored outside FETCH and FETCH2.

Reset
REQ-019 On rst: state=IDLE, cmd_addr=0, all outputs 0 (busy, done, err, cmd_rd_en, mst_o_*), internal captured data registers 0.
REQ-020 rst asserted mid-transaction SHALL abort immediately, with no completion of the outstanding bus request.

Structure
REQ-021 Package gp_engine_pkg SHALL hold the WRITE/RWM encodings, the command field bit positions and the state enum type.
REQ-022 A single FSM with registered outputs SHALL be used; optional sub-module gp_cmd_decode (combinational field split and type check).

Verification
REQ-023 Single WRITE {addr 0x100, data 0xDEADBEEF} then zero word -> one bus write 0x100 <= 0xDEADBEEF, then done pulse, err=0.
REQ-024 RWM {0x200, mask 0x0000FF00}, WRITE {0x200, 0x00001200}, bus read returns 0xAABBCCDD -> bus write 0x200 <= 0xAABB12DD.
REQ-025 RWM followed by RWM -> err=1, no bus write issued, busy falls.
REQ-026 mst_i_ready held low for 5 cycles during WR_REQ -> address and data held stable; exactly 1 write accepted.
REQ-027 Buffer full (entries through index 0x49C, all WRITE) -> 296 writes, stop at 0x4A0, done pulse.
REQ-028 rst pulsed while in RD_WAIT -> IDLE and all outputs 0 next cycle; a subsequent start runs cleanly from index 0.
